// File: rtl/tx_link_scheduler_pkg.sv
// Shared types and constants for the UART transmit link scheduler.
package tx_link_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic SRC_GAME = 1'b0;
    localparam logic SRC_CTRL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HI    = 2'd2,
        LO    = 2'd3
    } state_e;

    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC_CTRL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tx_link_scheduler_frame_timer.sv
// Periodic frame timer: pulses frame_start on each wrap unless the game-state
// source still owns the link, in which case a sticky overrun flag is raised.
module tx_frame_timer #(
    parameter int FRAME_PERIOD = 1666666,
    parameter int FRAME_CNT_W  = $clog2(FRAME_PERIOD)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src0_busy_i,
    output logic frame_start_o,
    output logic frame_overrun_o
);

    localparam logic [FRAME_CNT_W-1:0] LAST_CNT = FRAME_CNT_W'(FRAME_PERIOD - 1);

    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   wrap_s;

    always_comb begin
        wrap_s    = (cnt_q == LAST_CNT);
        cnt_d     = wrap_s ? {FRAME_CNT_W{1'b0}} : cnt_q + FRAME_CNT_W'(1);
        overrun_d = overrun_q | (wrap_s & src0_busy_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= {FRAME_CNT_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign frame_start_o   = wrap_s & ~src0_busy_i;
    assign frame_overrun_o = overrun_q;

endmodule

// File: rtl/tx_link_scheduler.sv
// Shares one UART byte channel between two 16-bit word-stream sources with
// packet-granular round-robin; optional stall timeout via TX_LINK_TIMEOUT_EN.
module tx_link_scheduler
    import tx_link_pkg::*;
#(
    parameter int FRAME_PERIOD   = 1666666,
    parameter int FRAME_CNT_W    = $clog2(FRAME_PERIOD),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic              frame_start,
    input  logic [WORD_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [WORD_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [BYTE_W-1:0] uart_data,
    output logic              uart_valid,
    input  logic              uart_ready,
    output logic [1:0]        grant,
    output logic              frame_overrun,
    output logic              pkt_abort
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              sel_valid_s, sel_last_s, accept_s, abort_s;
    logic [WORD_W-1:0] sel_data_s;

    assign sel_valid_s = (owner_q == SRC_CTRL) ? s1_valid : s0_valid;
    assign sel_data_s  = (owner_q == SRC_CTRL) ? s1_data  : s0_data;
    assign sel_last_s  = (owner_q == SRC_CTRL) ? s1_last  : s0_last;
    assign accept_s    = (state_q == GRANT) & sel_valid_s;

`ifdef TX_LINK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] stall_q, stall_d;
    logic            pkt_abort_q;

    always_comb begin
        abort_s = 1'b0;
        stall_d = {TO_W{1'b0}};
        if ((state_q == GRANT) && !sel_valid_s) begin
            abort_s = (stall_q == TO_W'(TIMEOUT_CYCLES - 1));
            stall_d = abort_s ? {TO_W{1'b0}} : stall_q + TO_W'(1);
        end else begin
            stall_d = {TO_W{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q     <= {TO_W{1'b0}};
            pkt_abort_q <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            pkt_abort_q <= abort_s;
        end
    end

    assign pkt_abort = pkt_abort_q;
`else
    assign abort_s   = 1'b0;
    assign pkt_abort = 1'b0;
`endif

    // Arbitrate only from IDLE so a packet keeps the link until its last word drains.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        last_d       = last_q;
        case (state_q)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    owner_d = ~last_grant_q;
                    state_d = GRANT;
                end else if (s0_valid) begin
                    owner_d = SRC_GAME;
                    state_d = GRANT;
                end else if (s1_valid) begin
                    owner_d = SRC_CTRL;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (accept_s) begin
                    word_d  = sel_data_s;
                    last_d  = sel_last_s;
                    state_d = HI;
                end else if (abort_s) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            HI: begin
                if (uart_ready) begin
                    state_d = LO;
                end else begin
                    state_d = HI;
                end
            end
            LO: begin
                if (uart_ready && last_q) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else if (uart_ready) begin
                    state_d = GRANT;
                end else begin
                    state_d = LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= SRC_GAME;
            last_grant_q <= SRC_CTRL;
            word_q       <= {WORD_W{1'b0}};
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            last_q       <= last_d;
        end
    end

    assign grant      = (state_q == IDLE) ? 2'b00 : src_onehot(owner_q);
    assign s0_ready   = (state_q == GRANT) && (owner_q == SRC_GAME);
    assign s1_ready   = (state_q == GRANT) && (owner_q == SRC_CTRL);
    assign uart_valid = (state_q == HI) || (state_q == LO);

    always_comb begin
        case (state_q)
            HI:      uart_data = word_q[WORD_W-1:BYTE_W];
            LO:      uart_data = word_q[BYTE_W-1:0];
            default: uart_data = {BYTE_W{1'b0}};
        endcase
    end

    tx_frame_timer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .FRAME_CNT_W  (FRAME_CNT_W)
    ) u_frame_timer (
        .clk_i           (clk),
        .rst_i           (rst),
        .src0_busy_i     ((state_q != IDLE) && (owner_q == SRC_GAME)),
        .frame_start_o   (frame_start),
        .frame_overrun_o (frame_overrun)
    );

endmodule
